// File: rtl/fx3_in_wb_writer_pkg.sv
// ---------------------------------------------------------------------------
// fx3_in_wb_writer_pkg
//   Shared definitions for the FX3 inbound Wishbone writer:
//   - state_t            : controller state encoding
//   - WRITE_CMD_DEF      : command code that moves data onto the bus
//   - FLAG_HOLD_BIT      : flag bit selecting a fixed (FIFO-style) target
//   - TIMEOUT_CYCLES_DEF : default ack wait limit (FX3_IN_WB_TIMEOUT_EN builds)
//   - WB_SEL_ALL         : byte selects for a full 32-bit word
// ---------------------------------------------------------------------------
package fx3_in_wb_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FIFO = 3'd1,
        ST_LOAD      = 3'd2,
        ST_BUS       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [7:0]  WRITE_CMD_DEF      = 8'h01;
    localparam int          FLAG_HOLD_BIT      = 0;
    localparam logic [31:0] TIMEOUT_CYCLES_DEF = 32'd1024;
    localparam logic [3:0]  WB_SEL_ALL         = 4'hF;

endpackage

// File: rtl/fx3_in_wb_writer_beat.sv
// ---------------------------------------------------------------------------
// fx3_in_wb_beat
//   Single-beat Wishbone write engine. A one-cycle i_start captures the data
//   word and raises stb/cyc on the following cycle; the strobe is held until
//   the slave acknowledges (or, when FX3_IN_WB_TIMEOUT_EN is defined, until
//   TIMEOUT_CYCLES strobe cycles pass without an ack).
//
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     i_start       : begin a beat with i_data
//     i_data        : word to write
//     i_ack         : Wishbone acknowledge
//     o_stb         : strobe (top drives cyc/we/stb from this)
//     o_sel         : byte selects, all ones while strobing
//     o_dat         : write data
//     o_beat_ack    : the beat completes this cycle
//     o_timeout     : the beat is abandoned this cycle
//
//   Configuration macro: FX3_IN_WB_TIMEOUT_EN
// ---------------------------------------------------------------------------
module fx3_in_wb_beat
    import fx3_in_wb_writer_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_data,
    input  logic        i_ack,
    output logic        o_stb,
    output logic [3:0]  o_sel,
    output logic [31:0] o_dat,
    output logic        o_beat_ack,
    output logic        o_timeout
);

    logic        stb_q, stb_d;
    logic [31:0] dat_q, dat_d;

    // An ack that is already high on the first strobe cycle finishes the beat
    // right away; acks outside a strobe are ignored.
    assign o_beat_ack = stb_q & i_ack;

`ifdef FX3_IN_WB_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;

    // timer_q holds the number of strobe cycles already spent without an ack,
    // so the limit is reached on the TIMEOUT_CYCLES-th waiting cycle.
    assign o_timeout = stb_q & ~i_ack & (timer_q == (TIMEOUT_CYCLES - 32'd1));

    always_comb begin
        timer_d = timer_q;
        if (!stb_q || i_ack) begin
            timer_d = 32'd0;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= 32'd0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign o_timeout          = 1'b0;
`endif

    always_comb begin
        stb_d = stb_q;
        dat_d = dat_q;
        if (i_start) begin
            stb_d = 1'b1;
            dat_d = i_data;
        end else if (o_beat_ack || o_timeout) begin
            stb_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            stb_q <= stb_d;
            dat_q <= dat_d;
        end
    end

    assign o_stb = stb_q;
    assign o_sel = stb_q ? WB_SEL_ALL : 4'h0;
    assign o_dat = dat_q;

endmodule

// File: rtl/fx3_in_wb_writer.sv
// ---------------------------------------------------------------------------
// fx3_in_wb_writer
//   Consumes decoded FX3 inbound command headers. Write commands drain words
//   from the ping-pong FIFO read side and issue one Wishbone write per word;
//   every accepted header ends with a one-cycle o_done_stb.
//
//   Ports:
//     clk, rst                       : clock, asynchronous active-low reset
//     i_command/i_flag/i_rw_count/
//     i_address/i_command_rdy_stb    : command header and its valid strobe
//     i_in_ready/o_in_activate/
//     i_in_packet_size/i_in_data/
//     o_in_strobe                    : ppfifo read side
//     o_wbm_*/i_wbm_ack              : Wishbone master (single-beat writes)
//     o_busy, o_done_stb,
//     o_word_count, o_error          : status to FX3 control logic
//
//   Configuration macro: FX3_IN_WB_TIMEOUT_EN (ack timeout sets o_error;
//   without it the bus waits indefinitely and o_error stays 0).
// ---------------------------------------------------------------------------
module fx3_in_wb_writer
    import fx3_in_wb_writer_pkg::*;
#(
    parameter logic [7:0]  WRITE_CMD      = WRITE_CMD_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_command,
    input  logic [7:0]  i_flag,
    input  logic [31:0] i_rw_count,
    input  logic [31:0] i_address,
    input  logic        i_command_rdy_stb,
    input  logic        i_in_ready,
    output logic        o_in_activate,
    input  logic [23:0] i_in_packet_size,
    input  logic [31:0] i_in_data,
    output logic        o_in_strobe,
    output logic [31:0] o_wbm_adr,
    output logic [31:0] o_wbm_dat,
    output logic [3:0]  o_wbm_sel,
    output logic        o_wbm_we,
    output logic        o_wbm_stb,
    output logic        o_wbm_cyc,
    input  logic        i_wbm_ack,
    output logic        o_busy,
    output logic        o_done_stb,
    output logic [31:0] o_word_count,
    output logic        o_error
);

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] word_count_q, word_count_d;
    logic [23:0] remaining_q, remaining_d;
    logic        hold_q, hold_d;
    logic        activate_q, activate_d;
    logic        error_q, error_d;

    logic        beat_start;
    logic        beat_stb;
    logic        beat_ack;
    logic        beat_timeout;
    logic [31:0] word_count_inc;

    logic        unused_flag_bits;
    assign unused_flag_bits = ^{i_flag[7:1]};

    // A word is popped in LOAD only while the claimed buffer still has data;
    // the same cycle hands that word to the beat engine.
    assign beat_start     = (state_q == ST_LOAD) && (remaining_q != 24'd0);
    assign word_count_inc = word_count_q + 32'd1;

    fx3_in_wb_beat #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_beat (
        .clk        (clk),
        .rst        (rst),
        .i_start    (beat_start),
        .i_data     (i_in_data),
        .i_ack      (i_wbm_ack),
        .o_stb      (beat_stb),
        .o_sel      (o_wbm_sel),
        .o_dat      (o_wbm_dat),
        .o_beat_ack (beat_ack),
        .o_timeout  (beat_timeout)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        adr_d        = adr_q;
        word_count_d = word_count_q;
        remaining_d  = remaining_q;
        hold_d       = hold_q;
        activate_d   = activate_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (i_command_rdy_stb) begin
                    count_d      = i_rw_count;
                    adr_d        = i_address;
                    hold_d       = i_flag[FLAG_HOLD_BIT];
                    word_count_d = 32'd0;
                    error_d      = 1'b0;
                    if ((i_command == WRITE_CMD) && (i_rw_count != 32'd0)) begin
                        state_d = ST_WAIT_FIFO;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WAIT_FIFO: begin
                if (i_in_ready) begin
                    activate_d  = 1'b1;
                    remaining_d = i_in_packet_size;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // An empty buffer is handed back; WAIT_FIFO then keeps
                // activate low for at least one cycle before re-claiming.
                if (remaining_q == 24'd0) begin
                    activate_d = 1'b0;
                    state_d    = ST_WAIT_FIFO;
                end else begin
                    state_d = ST_BUS;
                end
            end

            ST_BUS: begin
                if (beat_ack) begin
                    word_count_d = word_count_inc;
                    remaining_d  = remaining_q - 24'd1;
                    if (!hold_q) begin
                        adr_d = adr_q + 32'd1;
                    end
                    // Stopping exactly at count keeps o_word_count saturated
                    // and leaves any surplus words in the buffer unpopped.
                    if (word_count_inc == count_q) begin
                        activate_d = 1'b0;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (beat_timeout) begin
                    error_d    = 1'b1;
                    activate_d = 1'b0;
                    state_d    = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            count_q      <= 32'd0;
            adr_q        <= 32'd0;
            word_count_q <= 32'd0;
            remaining_q  <= 24'd0;
            hold_q       <= 1'b0;
            activate_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            adr_q        <= adr_d;
            word_count_q <= word_count_d;
            remaining_q  <= remaining_d;
            hold_q       <= hold_d;
            activate_q   <= activate_d;
            error_q      <= error_d;
        end
    end

    assign o_in_activate = activate_q;
    assign o_in_strobe   = beat_start;
    assign o_wbm_adr     = adr_q;
    assign o_wbm_we      = beat_stb;
    assign o_wbm_stb     = beat_stb;
    assign o_wbm_cyc     = beat_stb;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done_stb    = (state_q == ST_DONE);
    assign o_word_count  = word_count_q;
    assign o_error       = error_q;

endmodule

// File: doc/fx3_in_wb_writer.md
Name: fx3_in_wb_writer

Overview:
- Downstream consumer of the FX3 inbound command parser.
- Latches the decoded command header (command, flag, count, address) on the parser's command-ready strobe.
- For write commands, drains data words from the parser's ping-pong FIFO read side and issues single-beat Wishbone master writes.
- Reports completion and status back to the FX3 control logic.

Parameters:
- WRITE_CMD, 8'h01, command code that triggers a data transfer. All other codes complete with no bus activity.
- TIMEOUT_CYCLES, 32'd1024, ack wait limit. Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_command  in  8  latched command code
- i_flag  in  8  bit0=1: hold address (FIFO-style target); bit0=0: increment address
- i_rw_count  in  32  number of 32-bit words to write
- i_address  in  32  starting Wishbone word address
- i_command_rdy_stb  in  1  one-cycle header-valid strobe
- i_in_ready  in  1  a filled ppfifo buffer is available
- o_in_activate  out  1  claim the buffer for reading
- i_in_packet_size  in  24  words in the claimed buffer
- i_in_data  in  32  current buffer word
- o_in_strobe  out  1  pop the current word
- o_wbm_adr  out  32  bus address
- o_wbm_dat  out  32  write data
- o_wbm_sel  out  4  byte selects (always 4'hF when strobing)
- o_wbm_we  out  1  write enable
- o_wbm_stb  out  1  strobe
- o_wbm_cyc  out  1  cycle
- i_wbm_ack  in  1  acknowledge
- o_busy  out  1  transfer in progress
- o_done_stb  out  1  one-cycle completion pulse
- o_word_count  out  32  words acknowledged in the current or last command
- o_error  out  1  sticky error for the last command; cleared on the next header

Behaviour:
- Reset (rst low, asynchronous): every output drives 0; state=IDLE; internal counters clear.
- IDLE:
  - On i_command_rdy_stb, latch command, flag, count and address; clear o_word_count and o_error.
  - If command==WRITE_CMD and count>0, go to WAIT_FIFO.
  - Otherwise go to DONE.
  - A strobe arriving while not in IDLE is ignored.
- WAIT_FIFO: when i_in_ready=1, assert o_in_activate, load remaining-in-buffer from i_in_packet_size, go to LOAD.
- LOAD:
  - If remaining-in-buffer==0, deassert o_in_activate and go to WAIT_FIFO.
  - Otherwise capture i_in_data into o_wbm_dat and pulse o_in_strobe for 1 cycle.
  - Assert o_wbm_cyc, o_wbm_stb and o_wbm_we; set o_wbm_sel=4'hF; go to BUS.
- BUS:
  - Hold all bus signals until i_wbm_ack.
  - On ack: drop o_wbm_stb and o_wbm_cyc the next cycle; increment o_word_count; decrement remaining-in-buffer; add 1 to o_wbm_adr unless flag bit0=1.
  - If o_word_count+1==count, release o_in_activate and go to DONE; else go to LOAD.
- Ack that is already high when stb first rises completes that beat in the same cycle it is seen. Minimum beat is 2 cycles (LOAD plus BUS with immediate ack).
- Buffer exhausted mid-command: deassert o_in_activate for at least 1 cycle, then re-arbitrate in WAIT_FIFO.
- Buffer holds more words than needed: release it at command end. Leftover words are not popped.
- Address wraps modulo 2^32; o_word_count saturates at count.
- DONE: pulse o_done_stb for 1 cycle, return to IDLE.
- o_busy=1 in every state except IDLE.
- Reset mid-transfer: bus and FIFO outputs drop immediately (asynchronous). No done pulse is generated.

Optional Feature:
- Macro: FX3_IN_WB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs while in BUS and clears on each ack.
  - Reaching TIMEOUT_CYCLES without ack sets o_error, drops cyc/stb, releases o_in_activate, and goes to DONE (done pulse still issued).
- Undefined: BUS waits indefinitely; o_error is tied 0.

Decomposition:
- Shared package/include: state encodings (IDLE, WAIT_FIFO, LOAD, BUS, DONE), WRITE_CMD code, flag bit index for address hold, default TIMEOUT_CYCLES.
- Natural sub-module: fx3_in_wb_beat, a single Wishbone write-beat engine (stb/cyc/ack plus optional timeout) instantiated once.

Test Plan:
- Write, count=4, addr=32'h100, flag=0, one 8-word buffer, ack after 1-cycle delay:
  - Writes to 0x100..0x103 with data in FIFO order.
  - 4 strobes; activate released.
  - o_done_stb once; o_word_count=4.
- Write, count=6, buffers of 4 then 2 words:
  - Activate drops between buffers.
  - Addresses 0x0..0x5 are contiguous; done after 6 acks.
- Flag bit0=1, count=3, addr=0x40: all three writes to 0x40.
- Non-write command (8'h02):
  - No cyc, strobe or activate.
  - o_done_stb 1 cycle after the header strobe; o_busy high for exactly 1 cycle.
- FX3_IN_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never asserted:
  - After 16 BUS cycles, o_error=1, cyc=0 and done pulses.
  - The next header clears o_error.
- rst low during BUS of the 2nd word:
  - All outputs 0 immediately.
  - After release, a new count=1 command completes normally.
